pipeline_hazard_controller: RTL

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable inputs of the negedge-triggered pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC, and generates bubble/flush requests. It handles three events: load-use hazards, taken branches resolved in EX, and multi-cycle multiplies. A saturating stall counter supports performance measurement.

---
 rtl/mips_pipeline_pkg.sv | 19 +
 rtl/load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mips_pipeline_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline control blocks.
package mips_pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Hazard sequencer states.
    typedef enum logic {
        RUN       = 1'b0,
        MULT_WAIT = 1'b1
    } hz_state_e;

    // A write to $zero never creates a dependency, so it never matches.
    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] dst,
                                       input logic [REG_ADDR_W-1:0] src);
        reg_match = (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use dependency compare between the load in EX and the
// instruction in ID. Kept standalone so forwarding logic can reuse it.
module load_use_detect
    import mips_pipeline_pkg::*;
(
    input  logic                  mem_read_i,
    input  logic [REG_ADDR_W-1:0] load_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    output logic                  lu_o
);

    // Stall when the loaded register feeds Rs, or Rt if ID actually reads it.
    always_comb begin
        lu_o = 1'b0;
        if (mem_read_i) begin
            lu_o = reg_match(load_rt_i, id_rs_i) ||
                   (id_uses_rt_i && reg_match(load_rt_i, id_rt_i));
        end else begin
            lu_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. State advances on the
// falling clock edge, together with the pipeline registers it controls.
module pipeline_hazard_controller
    import mips_pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IDEX_MemRead,
    input  logic [REG_ADDR_W-1:0] IDEX_Rt,
    input  logic [REG_ADDR_W-1:0] IFID_Rs,
    input  logic [REG_ADDR_W-1:0] IFID_Rt,
    input  logic                  IFID_UsesRt,
    input  logic                  BranchTaken,
    input  logic                  MultStart,
    input  logic                  ClearCount,
    output logic                  PC_enable,
    output logic                  IFID_enable,
    output logic                  IFID_flush,
    output logic                  IDEX_enable,
    output logic                  IDEX_bubble,
    output logic                  EXMEM_enable,
    output logic                  EXMEM_bubble,
    output logic                  MEMWB_enable,
    output logic                  MultBusy,
    output logic [CNT_W-1:0]      StallCount
);

    // cnt is loaded with the remaining freeze cycles after the MultStart cycle.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);

    hz_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              lu_s;

    load_use_detect u_lu (
        .mem_read_i   (IDEX_MemRead),
        .load_rt_i    (IDEX_Rt),
        .id_rs_i      (IFID_Rs),
        .id_rt_i      (IFID_Rt),
        .id_uses_rt_i (IFID_UsesRt),
        .lu_o         (lu_s)
    );

    assign EXMEM_enable = 1'b1;
    assign MEMWB_enable = 1'b1;
    assign StallCount   = stall_cnt_q;

    // Next-state decode and pipeline control; reset forces a free-running pipe.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_enable    = 1'b1;
        IFID_enable  = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_enable  = 1'b1;
        IDEX_bubble  = 1'b0;
        EXMEM_bubble = 1'b0;
        MultBusy     = 1'b0;
        if (!reset) begin
            state_d = RUN;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (BranchTaken) begin
                        // Both younger instructions are wrong-path: squash them.
                        IFID_flush  = 1'b1;
                        IDEX_bubble = 1'b1;
                    end else if (MultStart) begin
                        PC_enable    = 1'b0;
                        IFID_enable  = 1'b0;
                        IDEX_enable  = 1'b0;
                        EXMEM_bubble = 1'b1;
                        cnt_d        = MULT_LOAD;
                        state_d      = MULT_WAIT;
                    end else if (lu_s) begin
                        // One bubble suffices: the load reaches MEM next cycle.
                        PC_enable   = 1'b0;
                        IFID_enable = 1'b0;
                        IDEX_bubble = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                MULT_WAIT: begin
                    MultBusy = 1'b1;
                    if (cnt_q != 4'd0) begin
                        PC_enable    = 1'b0;
                        IFID_enable  = 1'b0;
                        IDEX_enable  = 1'b0;
                        EXMEM_bubble = 1'b1;
                        cnt_d        = cnt_q - 4'd1;
                    end else begin
                        // Multiply leaves EX this cycle; pipeline runs freely.
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Saturating count of frozen-PC cycles; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ClearCount) begin
            stall_cnt_d = '0;
        end else if (!PC_enable && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Sequencer registers, updated with the pipeline registers on the falling edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
